// File: rtl/nand_cpu_pkg.sv
// Shared types for the nand_cpu memory path: request opcode and data cache FSM states.
package nand_cpu_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    RESPOND
  } d_cache_state_t;

endpackage

// File: rtl/d_cache_tag_array.sv
// Valid/dirty/tag storage for the direct-mapped data cache; combinational lookup, registered update.
module d_cache_tag_array #(
  parameter int LINES = 16,
  parameter int TAG_W = 10,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [IDX_W-1:0] idx,
  output logic             lk_valid,
  output logic             lk_dirty,
  output logic [TAG_W-1:0] lk_tag,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             set_dirty,
  input  logic             clr_dirty
);

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_mem [LINES];

  assign lk_valid = valid[idx];
  assign lk_dirty = dirty[idx];
  assign lk_tag   = tag_mem[idx];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < LINES; i++) tag_mem[i] <= '0;
    end else begin
      if (fill) begin
        valid[idx]   <= 1'b1;
        dirty[idx]   <= 1'b0;
        tag_mem[idx] <= fill_tag;
      end
      if (set_dirty) dirty[idx] <= 1'b1;
      if (clr_dirty) dirty[idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/d_cache_dm.sv
// Direct-mapped write-back, write-allocate data cache with a word-serial backing memory port.
//
// state     | meaning
// IDLE      | accepting requests; hits answered next cycle
// WRITEBACK | streaming dirty victim line out, one beat per mem_ack
// REFILL    | streaming requested line in, one beat per mem_ack
// RESPOND   | answer the missed request (merge store data), then back to IDLE
module d_cache_dm
  import nand_cpu_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int DM_W  = IDX_W + OFF_W;

  d_cache_state_t state, state_nxt;

  logic [OFF_W-1:0]  beat;
  logic              cap_op;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [TAG_W-1:0]  victim_tag;

  logic [DATA_W-1:0] data_mem [LINES*WORDS_PER_LINE];
  logic              dm_we;
  logic [DM_W-1:0]   dm_addr;
  logic [DATA_W-1:0] dm_wdata;

  logic [OFF_W-1:0] req_off, cap_off;
  logic [IDX_W-1:0] req_idx, cap_idx, lk_idx;
  logic [TAG_W-1:0] req_tag, cap_tag, lk_tag;
  logic             lk_valid, lk_dirty, hit, beat_last;
  logic             tag_fill, tag_set_dirty, tag_clr_dirty;

  assign req_off = req_addr[OFF_W-1:0];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign cap_off = cap_addr[OFF_W-1:0];
  assign cap_idx = cap_addr[OFF_W +: IDX_W];
  assign cap_tag = cap_addr[ADDR_W-1 -: TAG_W];

  // Lookup follows the incoming request in IDLE and the captured request otherwise.
  assign lk_idx    = (state == IDLE) ? req_idx : cap_idx;
  assign hit       = lk_valid && (lk_tag == req_tag);
  assign beat_last = &beat;

  d_cache_tag_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_tag_array (
    .clk       (clk),
    .n_rst     (n_rst),
    .idx       (lk_idx),
    .lk_valid  (lk_valid),
    .lk_dirty  (lk_dirty),
    .lk_tag    (lk_tag),
    .fill      (tag_fill),
    .fill_tag  (cap_tag),
    .set_dirty (tag_set_dirty),
    .clr_dirty (tag_clr_dirty)
  );

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    tag_fill      = 1'b0;
    tag_set_dirty = 1'b0;
    tag_clr_dirty = 1'b0;
    dm_we         = 1'b0;
    dm_addr       = {cap_idx, cap_off};
    dm_wdata      = cap_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (hit) begin
            if (req_op == MEM_WRITE) begin
              dm_we         = 1'b1;
              dm_addr       = {req_idx, req_off};
              dm_wdata      = req_wdata;
              tag_set_dirty = 1'b1;
            end
          end else if (lk_valid && lk_dirty) begin
            state_nxt = WRITEBACK;
          end else begin
            state_nxt = REFILL;
          end
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag, cap_idx, beat};
        mem_wdata = data_mem[{cap_idx, beat}];
        if (mem_ack && beat_last) begin
          tag_clr_dirty = 1'b1;
          state_nxt     = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {cap_tag, cap_idx, beat};
        if (mem_ack) begin
          dm_we    = 1'b1;
          dm_addr  = {cap_idx, beat};
          dm_wdata = mem_rdata;
          if (beat_last) begin
            tag_fill  = 1'b1;
            state_nxt = RESPOND;
          end
        end
      end
      RESPOND: begin
        state_nxt = IDLE;
        if (cap_op == MEM_WRITE) begin
          dm_we         = 1'b1;
          tag_set_dirty = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      beat       <= '0;
      cap_op     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      victim_tag <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      if (state == IDLE && req_valid) begin
        cap_op     <= req_op;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
        victim_tag <= lk_tag;
        if (hit) begin
          resp_valid <= 1'b1;
          if (req_op == MEM_READ) resp_data <= data_mem[{req_idx, req_off}];
        end
      end
      // The counter wraps to zero on the last beat, leaving it ready for the next phase.
      if (mem_req && mem_ack) beat <= beat + OFF_W'(1);
      if (state == RESPOND) begin
        resp_valid <= 1'b1;
        if (cap_op == MEM_READ) resp_data <= data_mem[{cap_idx, cap_off}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dm_we) data_mem[dm_addr] <= dm_wdata;
  end

endmodule

// File: tb/tb_d_cache_dm.sv
// Directed bench for d_cache_dm: memory model, beat and response scoreboards, latency checks.
module tb_d_cache_dm;
  import nand_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, resp_valid, mem_req, mem_we;
  logic [15:0] resp_data, mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } beat_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          beats = 0;
  int          ack_delay = 0;
  logic [15:0] resp_q[$];
  beat_t       mem_q[$];

  d_cache_dm dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic exp_beat(input logic we, input logic [15:0] a, input logic [15:0] wd);
    beat_t b;
    b.we = we; b.addr = a; b.wdata = wd;
    mem_q.push_back(b);
  endtask

  task automatic exp_refill(input logic [15:0] base);
    for (int i = 0; i < 4; i++) exp_beat(1'b0, base + 16'(i), 16'h0);
  endtask

  // Backing memory: acks after ack_delay idle cycles, checks held beats and the beat scoreboard.
  initial begin : mem_model
    int          wait_cnt;
    logic        hold;
    logic [32:0] held;
    beat_t       b;
    wait_cnt = 0;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (hold) begin
          checks++;
          assert ({mem_we, mem_addr, mem_wdata} === held) else begin
            errors++;
            $error("FAIL beat_stable got %h want %h", {mem_we, mem_addr, mem_wdata}, held);
          end
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(mem_addr);
          wait_cnt  = 0;
          hold      = 1'b0;
          beats++;
          checks++;
          assert (mem_q.size() != 0) else begin
            errors++;
            $error("FAIL beat_unexpected got we=%b addr=%h want none", mem_we, mem_addr);
          end
          if (mem_q.size() != 0) begin
            b = mem_q.pop_front();
            checks++;
            assert ({mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0)} === {b.we, b.addr, b.wdata}) else begin
              errors++;
              $error("FAIL beat got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                     mem_we, mem_addr, mem_wdata, b.we, b.addr, b.wdata);
            end
          end
        end else begin
          wait_cnt++;
          hold = 1'b1;
          held = {mem_we, mem_addr, mem_wdata};
        end
      end else begin
        wait_cnt = 0;
        hold = 1'b0;
      end
    end
  end

  initial begin : resp_monitor
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        checks++;
        assert (resp_q.size() != 0) else begin
          errors++;
          $error("FAIL resp_unexpected got %h want none", resp_data);
        end
        if (resp_q.size() != 0) begin
          exp = resp_q.pop_front();
          checks++;
          assert (resp_data === exp) else begin
            errors++;
            $error("FAIL resp_data got %h want %h", resp_data, exp);
          end
        end
      end
    end
  end

  // One request; latency counts the acceptance cycle as cycle 1.
  task automatic do_req(input string tag, input logic op, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_d, input int exp_lat);
    int n;
    int acc;
    bit got;
    @(posedge clk); #1;
    resp_q.push_back(exp_d);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (resp_valid === 1'b1) begin got = 1'b1; break; end
      if (exp_lat > 1) chk({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_latency"}, 32'(cyc - acc + 1), 32'(exp_lat));
      chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin : stim
    int n;
    int b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    exp_refill(16'h0010);
    do_req("cold_miss", MEM_READ, 16'h0012, 16'h0, 16'hA5B7, 6);

    b0 = beats;
    do_req("hit_rd", MEM_READ, 16'h0013, 16'h0, 16'hA5B6, 1);
    do_req("st_hit", MEM_WRITE, 16'h0011, 16'hBEEF, 16'h0000, 1);
    do_req("ld_after_st", MEM_READ, 16'h0011, 16'h0, 16'hBEEF, 1);
    chk("hits_no_mem", 32'(beats), 32'(b0));

    exp_beat(1'b1, 16'h0010, 16'hA5B5);
    exp_beat(1'b1, 16'h0011, 16'hBEEF);
    exp_beat(1'b1, 16'h0012, 16'hA5B7);
    exp_beat(1'b1, 16'h0013, 16'hA5B6);
    exp_refill(16'h0110);
    do_req("dirty_miss", MEM_READ, 16'h0111, 16'h0, 16'hA4B4, 10);

    b0 = beats;
    @(posedge clk); #1;
    resp_q.push_back(16'hA4B7);
    resp_q.push_back(16'hA4B6);
    req_valid = 1'b1; req_op = MEM_READ; req_addr = 16'h0112;
    @(negedge clk);
    chk("b2b_ready1", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_addr = 16'h0113;
    @(negedge clk);
    chk("b2b_ready2", 32'(req_ready), 32'd1);
    chk("b2b_resp1", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_resp2", 32'(resp_valid), 32'd1);
    chk("b2b_no_mem", 32'(beats), 32'(b0));

    ack_delay = 3;
    exp_refill(16'h0344);
    do_req("st_miss_slow", MEM_WRITE, 16'h0345, 16'h1234, 16'h0000, 18);
    do_req("ld_slow_hit", MEM_READ, 16'h0345, 16'h0, 16'h1234, 1);
    exp_beat(1'b1, 16'h0344, 16'hA6E1);
    exp_beat(1'b1, 16'h0345, 16'h1234);
    exp_beat(1'b1, 16'h0346, 16'hA6E3);
    exp_beat(1'b1, 16'h0347, 16'hA6E2);
    exp_refill(16'h0744);
    do_req("dirty_slow", MEM_READ, 16'h0744, 16'h0, 16'hA2E1, 34);

    exp_beat(1'b0, 16'h0220, 16'h0);
    exp_beat(1'b0, 16'h0221, 16'h0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = MEM_READ; req_addr = 16'h0222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (mem_addr !== 16'h0222 && n < 200);
    chk("rst_reach_beat2", 32'(mem_addr), 32'h0222);
    n_rst = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    ack_delay = 0;
    exp_refill(16'h0220);
    do_req("post_rst_miss", MEM_READ, 16'h0222, 16'h0, 16'hA787, 6);
    exp_refill(16'h0110);
    do_req("post_rst_line0", MEM_READ, 16'h0111, 16'h0, 16'hA4B4, 6);

    repeat (2) @(negedge clk);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
